// File: rtl/div_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_if
// Description : Request/response bundle for the iterative divider. Carries
//               the request handshake with its operands and flags, the
//               flush strobe, and the result handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   in_valid / in_ready     request handshake (in_ready driven by divider)
//   a, b                    dividend / divisor
//   is_unsigned, is_rem,    operation flags
//   is_word
//   flush                   abort any in-flight operation
//   out_valid / out_ready   result handshake (out_valid driven by divider)
//   c                       result
// Modports:
//   master - requester / consumer side (execute stage)
//   slave  - divider side
// ============================================================================
interface div_iter_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            is_unsigned;
  logic            is_rem;
  logic            is_word;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] c;

  modport master (
    output in_valid, a, b, is_unsigned, is_rem, is_word, flush, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, is_unsigned, is_rem, is_word, flush, out_ready,
    output in_ready, out_valid, c
  );
endinterface
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Iterative radix-2 restoring divider for the RV64M
//               DIV/DIVU/REM/REMU and *W group. One quotient bit per cycle;
//               divide-by-zero and signed overflow resolve in one cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high reset
//   bus    slave modport of div_iter_if (request, flush, result)
// Parameters:
//   XLEN   operand/result width; only 64 is supported
// ============================================================================
module div_iter #(
  parameter int XLEN = 64
) (
  input  logic      clk,
  input  logic      reset,
  div_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state;
  logic [6:0]      count;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic            neg_q;
  logic            neg_r;
  logic            sel_rem;
  logic            word;
  logic            out_valid_q;
  logic [XLEN-1:0] c_q;

  // Sign-extend the low word for *W results, pass through otherwise.
  function automatic logic [XLEN-1:0] fit(input logic w, input logic [XLEN-1:0] v);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // ---------------- accept-side decode ----------------
  logic            sa, sb;
  logic [XLEN-1:0] a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            b_zero, a_min, b_m1, ovf;

  always_comb begin
    a_neg  = -bus.a;
    b_neg  = -bus.b;
    sa     = !bus.is_unsigned && (bus.is_word ? bus.a[31] : bus.a[63]);
    sb     = !bus.is_unsigned && (bus.is_word ? bus.b[31] : bus.b[63]);
    // Low 32 bits of the 64-bit negation equal the 32-bit negation.
    if (bus.is_word) begin
      a_abs = {32'd0, (sa ? a_neg[31:0] : bus.a[31:0])};
      b_abs = {32'd0, (sb ? b_neg[31:0] : bus.b[31:0])};
    end else begin
      a_abs = sa ? a_neg : bus.a;
      b_abs = sb ? b_neg : bus.b;
    end
    b_zero = bus.is_word ? (bus.b[31:0] == 32'd0) : (bus.b == '0);
    a_min  = bus.is_word ? (bus.a[31:0] == 32'h8000_0000)
                         : (bus.a == {1'b1, {(XLEN-1){1'b0}}});
    b_m1   = bus.is_word ? (bus.b[31:0] == 32'hFFFF_FFFF) : (bus.b == '1);
    ovf    = !bus.is_unsigned && a_min && b_m1;
  end

  // ---------------- one restoring step ----------------
  // The partial remainder is below the divisor, so the shifted trial value
  // needs one extra bit and the restored value always fits back in XLEN.
  logic [XLEN:0]   trial, diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx, quo_nx, q_fin, r_fin, result;

  always_comb begin
    trial  = {rem, dividend[XLEN-1]};
    diff   = trial - {1'b0, divisor};
    ge     = (trial >= {1'b0, divisor});
    rem_nx = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
    quo_nx = {quo[XLEN-2:0], ge};
    q_fin  = neg_q ? -quo_nx : quo_nx;
    r_fin  = neg_r ? -rem_nx : rem_nx;
    result = fit(word, sel_rem ? r_fin : q_fin);
  end

  // ---------------- control and state ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= 7'd0;
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      quo         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      sel_rem     <= 1'b0;
      word        <= 1'b0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
    end else if (bus.flush) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      c_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sel_rem <= bus.is_rem;
            word    <= bus.is_word;
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            divisor <= b_abs;
            rem     <= '0;
            quo     <= '0;
            // Word operands are left-justified so the step always takes bit 63.
            dividend <= bus.is_word ? {a_abs[31:0], 32'd0} : a_abs;
            if (b_zero) begin
              c_q         <= bus.is_rem ? fit(bus.is_word, bus.a) : '1;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else if (ovf) begin
              c_q         <= bus.is_rem ? '0 : fit(bus.is_word, bus.a);
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              count <= bus.is_word ? 7'd32 : 7'd64;
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          dividend <= {dividend[XLEN-2:0], 1'b0};
          rem      <= rem_nx;
          quo      <= quo_nx;
          count    <= count - 7'd1;
          if (count == 7'd1) begin
            c_q         <= result;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;

endmodule
`default_nettype wire
